// File: rtl/lcd_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_receiver
// Description : Display-side end of the serial LCD link. Oversamples the
//               scl/sda/cs/rs wires, deserialises bytes MSB-first, decodes
//               CASET/RASET/RAMWR and emits RGB565 pixel writes with x/y.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_receiver #(
  parameter int XMAX = 159,
  parameter int YMAX = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda,
  input  logic        cs,
  input  logic        rs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_rs,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        frame_done,
  output logic        cmd_err
);

  localparam logic [7:0] c_XMAX = XMAX[7:0];
  localparam logic [7:0] c_YMAX = YMAX[7:0];

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CASET    = 3'd1,
    S_RASET    = 3'd2,
    S_RAMWR_HI = 3'd3,
    S_RAMWR_LO = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers and scl edge detect
  // --------------------------------------------------------------------------
  logic [1:0] r_scl_sync, r_sda_sync, r_cs_sync, r_rs_sync;
  logic       r_scl_prev;
  logic       w_scl_rise, w_sda_s, w_cs_s, w_rs_s;

  // Two-flop synchronisers on every link wire, plus a delayed copy of scl.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 2'b00;
      r_sda_sync <= 2'b00;
      r_cs_sync  <= 2'b00;
      r_rs_sync  <= 2'b00;
      r_scl_prev <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_cs_sync  <= {r_cs_sync[0], cs};
      r_rs_sync  <= {r_rs_sync[0], rs};
      r_scl_prev <= r_scl_sync[1];
    end
  end

  assign w_scl_rise = r_scl_sync[1] & ~r_scl_prev;
  assign w_sda_s    = r_sda_sync[1];
  assign w_cs_s     = r_cs_sync[1];
  assign w_rs_s     = r_rs_sync[1];

  // --------------------------------------------------------------------------
  // Deserialiser
  // --------------------------------------------------------------------------
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic       r_byte_valid;
  logic [7:0] r_byte_data;
  logic       r_byte_rs;

  // Shift in one bit per scl rise while selected; deselect drops a partial byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt    <= 3'd0;
      r_shift      <= 7'd0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
      r_byte_rs    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_cs_s) begin
        r_bit_cnt <= 3'd0;
      end else if (w_scl_rise) begin
        r_shift   <= {r_shift[5:0], w_sda_s};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_data  <= {r_shift, w_sda_s};
          r_byte_rs    <= w_rs_s;
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command decoder
  // --------------------------------------------------------------------------
  state_t      r_state, w_state_n;
  logic [1:0]  r_pidx, w_pidx_n;
  logic        r_hi_bad, w_hi_bad_n;
  logic [7:0]  r_p_lo, w_p_lo_n;
  logic [7:0]  r_xs, r_xe, w_xs_n, w_xe_n;
  logic [6:0]  r_ys, r_ye, w_ys_n, w_ye_n;
  logic [7:0]  r_x, w_x_n;
  logic [6:0]  r_y, w_y_n;
  logic [7:0]  r_hi, w_hi_n;
  logic        r_pix_valid, w_pix_valid_n;
  logic [7:0]  r_pix_x, w_pix_x_n;
  logic [6:0]  r_pix_y, w_pix_y_n;
  logic [15:0] r_pix_rgb, w_pix_rgb_n;
  logic        r_frame_done, w_frame_done_n;
  logic        r_cmd_err, w_cmd_err_n;
  logic        w_win_ok;
  logic [7:0]  w_lim;

  // Decoder state register; the window defaults to the full screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pidx       <= 2'd0;
      r_hi_bad     <= 1'b0;
      r_p_lo       <= 8'd0;
      r_xs         <= 8'd0;
      r_xe         <= c_XMAX;
      r_ys         <= 7'd0;
      r_ye         <= c_YMAX[6:0];
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_hi         <= 8'd0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= 8'd0;
      r_pix_y      <= 7'd0;
      r_pix_rgb    <= 16'd0;
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pidx       <= w_pidx_n;
      r_hi_bad     <= w_hi_bad_n;
      r_p_lo       <= w_p_lo_n;
      r_xs         <= w_xs_n;
      r_xe         <= w_xe_n;
      r_ys         <= w_ys_n;
      r_ye         <= w_ye_n;
      r_x          <= w_x_n;
      r_y          <= w_y_n;
      r_hi         <= w_hi_n;
      r_pix_valid  <= w_pix_valid_n;
      r_pix_x      <= w_pix_x_n;
      r_pix_y      <= w_pix_y_n;
      r_pix_rgb    <= w_pix_rgb_n;
      r_frame_done <= w_frame_done_n;
      r_cmd_err    <= w_cmd_err_n;
    end
  end

  // Next-state logic: a command byte always restarts decoding from IDLE rules.
  always_comb begin
    w_state_n      = r_state;
    w_pidx_n       = r_pidx;
    w_hi_bad_n     = r_hi_bad;
    w_p_lo_n       = r_p_lo;
    w_xs_n         = r_xs;
    w_xe_n         = r_xe;
    w_ys_n         = r_ys;
    w_ye_n         = r_ye;
    w_x_n          = r_x;
    w_y_n          = r_y;
    w_hi_n         = r_hi;
    w_pix_valid_n  = 1'b0;
    w_pix_x_n      = r_pix_x;
    w_pix_y_n      = r_pix_y;
    w_pix_rgb_n    = r_pix_rgb;
    w_frame_done_n = 1'b0;
    w_cmd_err_n    = 1'b0;
    w_win_ok       = 1'b0;
    w_lim          = c_XMAX;
    if (r_byte_valid) begin
      if (!r_byte_rs) begin
        w_pidx_n   = 2'd0;
        w_hi_bad_n = 1'b0;
        case (r_byte_data)
          8'h2A:   w_state_n = S_CASET;
          8'h2B:   w_state_n = S_RASET;
          8'h2C: begin
            w_state_n = S_RAMWR_HI;
            w_x_n     = r_xs;
            w_y_n     = r_ys;
          end
          default: w_state_n = S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_CASET, S_RASET: begin
            w_pidx_n = r_pidx + 2'd1;
            case (r_pidx)
              2'd0:    w_hi_bad_n = (r_byte_data != 8'd0);
              2'd1:    w_p_lo_n   = r_byte_data;
              2'd2:    w_hi_bad_n = r_hi_bad | (r_byte_data != 8'd0);
              default: begin
                // Validate on full 8 bits before any truncation to row width.
                w_lim    = (r_state == S_CASET) ? c_XMAX : c_YMAX;
                w_win_ok = !r_hi_bad && (r_p_lo <= r_byte_data) && (r_byte_data <= w_lim);
                if (w_win_ok) begin
                  if (r_state == S_CASET) begin
                    w_xs_n = r_p_lo;
                    w_xe_n = r_byte_data;
                  end else begin
                    w_ys_n = r_p_lo[6:0];
                    w_ye_n = r_byte_data[6:0];
                  end
                end else begin
                  w_cmd_err_n = 1'b1;
                end
                w_state_n = S_IDLE;
                w_pidx_n  = 2'd0;
              end
            endcase
          end
          S_RAMWR_HI: begin
            w_hi_n    = r_byte_data;
            w_state_n = S_RAMWR_LO;
          end
          S_RAMWR_LO: begin
            w_pix_valid_n = 1'b1;
            w_pix_x_n     = r_x;
            w_pix_y_n     = r_y;
            w_pix_rgb_n   = {r_hi, r_byte_data};
            w_state_n     = S_RAMWR_HI;
            if (r_x == r_xe) begin
              w_x_n = r_xs;
              if (r_y == r_ye) begin
                w_y_n          = r_ys;
                w_frame_done_n = 1'b1;
              end else begin
                w_y_n = r_y + 7'd1;
              end
            end else begin
              w_x_n = r_x + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign byte_rs    = r_byte_rs;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_rgb    = r_pix_rgb;
  assign frame_done = r_frame_done;
  assign cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_receiver
// Description : Scoreboard bench for lcd_spi_receiver. Two instances share the
//               serial wires: a full-size one and a tiny-screen one used for
//               whole-frame wrap checks. Each has its own chip select.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_receiver;

  localparam int SX = 5;
  localparam int SY = 3;

  logic clk = 1'b0, reset = 1'b1;
  logic scl = 1'b0, sda = 1'b0, cs = 1'b1, cs_s = 1'b1, rs = 1'b0;

  logic        a_bv, a_brs, a_pv, a_fd, a_err;
  logic [7:0]  a_bd, a_px;
  logic [6:0]  a_py;
  logic [15:0] a_rgb;
  logic        b_bv, b_brs, b_pv, b_fd, b_err;
  logic [7:0]  b_bd, b_px;
  logic [6:0]  b_py;
  logic [15:0] b_rgb;

  lcd_spi_receiver dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .cs(cs), .rs(rs),
    .byte_valid(a_bv), .byte_data(a_bd), .byte_rs(a_brs),
    .pix_valid(a_pv), .pix_x(a_px), .pix_y(a_py), .pix_rgb(a_rgb),
    .frame_done(a_fd), .cmd_err(a_err)
  );

  lcd_spi_receiver #(.XMAX(SX), .YMAX(SY)) dut_s (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .cs(cs_s), .rs(rs),
    .byte_valid(b_bv), .byte_data(b_bd), .byte_rs(b_brs),
    .pix_valid(b_pv), .pix_x(b_px), .pix_y(b_py), .pix_rgb(b_rgb),
    .frame_done(b_fd), .cmd_err(b_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues, one set per instance.
  logic [8:0]  q_byte0[$], q_byte1[$];
  logic [31:0] q_pix0[$], q_pix1[$];
  int          err_pend[2];
  int          fd_cnt1 = 0;

  // Reference model state: window, pending parameters, pixels since RAMWR.
  int         m_st[2];      // 0 idle, 1 column window, 2 row window, 3 pixel write
  int         m_np[2];
  int         m_par[2][4];
  int         m_xs[2], m_xe[2], m_ys[2], m_ye[2];
  int         m_pix[2];
  logic [7:0] m_hi[2];
  bit         m_have[2];
  int         m_xmax[2] = '{159, SX};
  int         m_ymax[2] = '{127, SY};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_np[i] = 0; m_pix[i] = 0; m_have[i] = 0;
      m_xs[i] = 0; m_xe[i] = m_xmax[i];
      m_ys[i] = 0; m_ye[i] = m_ymax[i];
    end
  endfunction

  function automatic void model_byte(int i, bit r, logic [7:0] d);
    int w, h, n, px, py, lim;
    logic [31:0] e;
    if (i == 0) q_byte0.push_back({r, d}); else q_byte1.push_back({r, d});
    if (!r) begin
      m_np[i] = 0; m_have[i] = 0;
      case (d)
        8'h2A:   m_st[i] = 1;
        8'h2B:   m_st[i] = 2;
        8'h2C: begin m_st[i] = 3; m_pix[i] = 0; end
        default: m_st[i] = 0;
      endcase
    end else if (m_st[i] == 1 || m_st[i] == 2) begin
      m_par[i][m_np[i]] = int'(d);
      m_np[i]++;
      if (m_np[i] == 4) begin
        lim = (m_st[i] == 1) ? m_xmax[i] : m_ymax[i];
        if (m_par[i][0] == 0 && m_par[i][2] == 0 &&
            m_par[i][1] <= m_par[i][3] && m_par[i][3] <= lim) begin
          if (m_st[i] == 1) begin m_xs[i] = m_par[i][1]; m_xe[i] = m_par[i][3]; end
          else              begin m_ys[i] = m_par[i][1]; m_ye[i] = m_par[i][3]; end
        end else begin
          err_pend[i]++;
        end
        m_st[i] = 0; m_np[i] = 0;
      end
    end else if (m_st[i] == 3) begin
      if (!m_have[i]) begin
        m_hi[i] = d; m_have[i] = 1;
      end else begin
        m_have[i] = 0;
        w  = m_xe[i] - m_xs[i] + 1;
        h  = m_ye[i] - m_ys[i] + 1;
        n  = m_pix[i] % (w * h);
        px = m_xs[i] + n % w;
        py = m_ys[i] + n / w;
        e  = {px[7:0], py[6:0], m_hi[i], d, (n == w * h - 1)};
        m_pix[i]++;
        if (i == 0) q_pix0.push_back(e); else q_pix1.push_back(e);
      end
    end
  endfunction

  // Monitor: pop and compare whenever either instance presents an output.
  always @(negedge clk) begin
    logic [8:0]  eb;
    logic [31:0] ep;
    if (a_bv) begin
      if (q_byte0.size() == 0) chk("byte0_unexpected", {23'd0, a_brs, a_bd}, 32'h1FF);
      else begin eb = q_byte0.pop_front(); chk("byte0", {23'd0, a_brs, a_bd}, {23'd0, eb}); end
    end
    if (a_pv) begin
      if (q_pix0.size() == 0) chk("pix0_unexpected", {a_px, a_py, a_rgb, a_fd}, 32'hFFFFFFFF);
      else begin ep = q_pix0.pop_front(); chk("pix0", {a_px, a_py, a_rgb, a_fd}, ep); end
    end
    if (a_fd && !a_pv) chk("fd0_without_pix", 32'd1, 32'd0);
    if (a_err) begin
      chk("cmd_err0_expected", {31'd0, err_pend[0] > 0}, 32'd1);
      if (err_pend[0] > 0) err_pend[0]--;
    end
    if (b_bv) begin
      if (q_byte1.size() == 0) chk("byte1_unexpected", {23'd0, b_brs, b_bd}, 32'h1FF);
      else begin eb = q_byte1.pop_front(); chk("byte1", {23'd0, b_brs, b_bd}, {23'd0, eb}); end
    end
    if (b_pv) begin
      if (b_fd) fd_cnt1++;
      if (q_pix1.size() == 0) chk("pix1_unexpected", {b_px, b_py, b_rgb, b_fd}, 32'hFFFFFFFF);
      else begin ep = q_pix1.pop_front(); chk("pix1", {b_px, b_py, b_rgb, b_fd}, ep); end
    end
    if (b_fd && !b_pv) chk("fd1_without_pix", 32'd1, 32'd0);
    if (b_err) begin
      chk("cmd_err1_expected", {31'd0, err_pend[1] > 0}, 32'd1);
      if (err_pend[1] > 0) err_pend[1]--;
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(bit r, logic [7:0] d, int n, int half);
    rs = r;
    for (int b = 7; b > 7 - n; b--) begin
      scl = 1'b0;
      sda = d[b];
      wait_clk(half);
      scl = 1'b1;
      wait_clk(half);
    end
    scl = 1'b0;
  endtask

  task automatic send_byte(int i, bit r, logic [7:0] d, int half);
    model_byte(i, r, d);
    send_bits(r, d, 8, half);
  endtask

  task automatic cmd4(int i, input logic [7:0] c, p0, p1, p2, p3);
    send_byte(i, 1'b0, c, 4);
    send_byte(i, 1'b1, p0, 4);
    send_byte(i, 1'b1, p1, 4);
    send_byte(i, 1'b1, p2, 4);
    send_byte(i, 1'b1, p3, 4);
  endtask

  task automatic pix(int i, input logic [15:0] v, int half);
    send_byte(i, 1'b1, v[15:8], half);
    send_byte(i, 1'b1, v[7:0], half);
  endtask

  task automatic drain(string nm);
    int t;
    t = 0;
    while ((q_byte0.size() + q_byte1.size() + q_pix0.size() + q_pix1.size()
            + err_pend[0] + err_pend[1]) != 0 && t < 300) begin
      wait_clk(1);
      t++;
    end
    chk({nm, "_pending_outputs"},
        q_byte0.size() + q_byte1.size() + q_pix0.size() + q_pix1.size() + err_pend[0] + err_pend[1],
        32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    wait_clk(3);
    chk("rst_byte_valid", {31'd0, a_bv}, 32'd0);
    chk("rst_byte_data",  {24'd0, a_bd}, 32'd0);
    chk("rst_pix",        {a_px, a_py, a_rgb, a_pv}, 32'd0);
    chk("rst_fd_err",     {30'd0, a_fd, a_err}, 32'd0);
    chk("rst_small",      {b_bv, b_pv, b_fd, b_err, b_px, b_py}, 32'd0);
    reset = 1'b0;
    wait_clk(3);
  endtask

  initial begin
    int op, n, half, xs, xe, v, lim;
    logic [7:0] p0, p2, lo, hi;
    err_pend[0] = 0; err_pend[1] = 0;
    do_reset();
    cs = 1'b0;
    wait_clk(4);

    // Plain data byte in IDLE: one byte pulse, no pixel.
    send_byte(0, 1'b1, 8'hA5, 4);
    // Partial byte dropped by deselect.
    send_bits(1'b1, 8'hE0, 3, 4);
    cs = 1'b1; wait_clk(6); cs = 1'b0; wait_clk(4);
    send_byte(0, 1'b1, 8'h3C, 4);
    // 2x2 window, one frame plus wrap.
    cmd4(0, 8'h2A, 8'h00, 8'h10, 8'h00, 8'h11);
    cmd4(0, 8'h2B, 8'h00, 8'h20, 8'h00, 8'h21);
    send_byte(0, 1'b0, 8'h2C, 4);
    pix(0, 16'hF800, 4); pix(0, 16'h07E0, 4); pix(0, 16'h001F, 4); pix(0, 16'hFFFF, 4);
    pix(0, 16'h1234, 4);
    // Rejected window keeps the old one.
    cmd4(0, 8'h2A, 8'h00, 8'h50, 8'h00, 8'h40);
    send_byte(0, 1'b0, 8'h2C, 4);
    pix(0, 16'h1111, 3); pix(0, 16'h2222, 3); pix(0, 16'h3333, 3);
    // Pending high byte discarded by a new command.
    send_byte(0, 1'b0, 8'h2C, 4);
    send_byte(0, 1'b1, 8'hAB, 4);
    send_byte(0, 1'b0, 8'h2C, 4);
    pix(0, 16'hABCD, 4);
    drain("directed");

    // Reset in the middle of a row-window parameter.
    send_byte(0, 1'b0, 8'h2B, 4);
    send_byte(0, 1'b1, 8'h00, 4);
    send_bits(1'b1, 8'h20, 5, 4);
    drain("pre_reset");
    do_reset();
    send_byte(0, 1'b0, 8'h2C, 4);
    pix(0, 16'h5A5A, 3); pix(0, 16'hC3C3, 3);
    drain("after_reset");

    // Randomised command / data stream.
    for (int k = 0; k < 60; k++) begin
      op   = $urandom_range(6, 0);
      half = $urandom_range(5, 3);
      case (op)
        0, 1: begin
          lim = (op == 0) ? 159 : 127;
          xs  = $urandom_range(lim, 0);
          xe  = xs + $urandom_range(3, 0);
          if (xe > lim) xe = lim;
          p0 = 8'd0; p2 = 8'd0;
          v = $urandom_range(4, 0);
          if (v == 0) p0 = 8'($urandom_range(255, 1));
          if (v == 1 && xs > 0) xe = xs - 1;
          if (v == 2) xe = $urandom_range(255, lim + 1);
          if (v == 3) p2 = 8'($urandom_range(255, 1));
          send_byte(0, 1'b0, (op == 0) ? 8'h2A : 8'h2B, half);
          send_byte(0, 1'b1, p0, half);
          send_byte(0, 1'b1, xs[7:0], half);
          send_byte(0, 1'b1, p2, half);
          send_byte(0, 1'b1, xe[7:0], half);
        end
        2: begin
          send_byte(0, 1'b0, 8'h2C, half);
          n = $urandom_range(8, 1);
          for (int j = 0; j < n; j++) pix(0, 16'($urandom), half);
        end
        3: send_byte(0, 1'b0, 8'($urandom), half);
        4: send_byte(0, 1'b1, 8'($urandom), half);
        5: begin
          send_byte(0, 1'b0, 8'h2C, half);
          hi = 8'($urandom);
          send_byte(0, 1'b1, hi, half);
        end
        default: begin
          send_byte(0, 1'b0, ($urandom_range(1, 0) == 0) ? 8'h2A : 8'h2B, half);
          n = $urandom_range(3, 1);
          for (int j = 0; j < n; j++) begin
            lo = 8'($urandom_range(40, 0));
            send_byte(0, 1'b1, lo, half);
          end
        end
      endcase
    end
    drain("random");

    // Whole-frame wrap on the small screen straight after reset.
    cs = 1'b1;
    wait_clk(4);
    do_reset();
    cs_s = 1'b0;
    wait_clk(4);
    send_byte(1, 1'b0, 8'h2C, 3);
    for (int j = 0; j < (SX + 1) * (SY + 1) + 1; j++) pix(1, 16'($urandom), 3);
    drain("small_frame");
    chk("small_frame_done_count", fd_cnt1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_spi_receiver.md
Name: lcd_spi_receiver

Overview:
- Display-side end of the serial LCD link (sda/scl/cs/rs) driven by the screen transmitter.
- Oversamples the four link wires on the system clock and deserialises bytes MSB-first.
- Decodes the ST7735-style command subset CASET/RASET/RAMWR and emits RGB565 pixel writes with x/y coordinates.
- Used as a bench/capture model and as a framebuffer write front-end.

Parameters:
- XMAX, 159, last valid column
- YMAX, 127, last valid row

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scl  input  1  serial clock, asynchronous to clk
- sda  input  1  serial data, sampled on scl rising edge
- cs  input  1  chip select, active-low
- rs  input  1  0=command byte, 1=data byte
- byte_valid  output  1  one-cycle pulse, byte received
- byte_data  output  8  received byte
- byte_rs  output  1  rs value latched with the byte
- pix_valid  output  1  one-cycle pulse, pixel complete
- pix_x  output  8  pixel column
- pix_y  output  7  pixel row
- pix_rgb  output  16  RGB565 pixel, high byte first on the wire
- frame_done  output  1  pulse coincident with pix_valid of the last pixel in the window
- cmd_err  output  1  pulse, rejected CASET/RASET window

Behaviour:
- Reset values:
  - all outputs 0; FSM=IDLE; bit count 0.
  - window xs=0, xe=XMAX, ys=0, ye=YMAX; x=0, y=0.
- Synchronisers:
  - scl, sda, cs, rs each pass through 2 flops.
  - scl rise = synced scl 1 while previous synced scl 0.
  - Let k be the first clk edge that samples raw scl=1. The rise is detected in the cycle after edge k+1. Results register at edge k+2.
- Deserialiser:
  - On an scl rise with synced cs=0: shift synced sda in MSB-first and increment the bit count (3 bits).
  - On the 8th bit: byte_data and byte_rs (synced rs at that edge) are registered and byte_valid pulses for exactly 1 cycle. The bit count returns to 0.
  - Synced cs=1 clears the bit count and discards any partial byte. FSM state and window are NOT affected.
  - scl rises while cs=1 are ignored.
- Decoder FSM, advanced only on byte_valid:
  - IDLE: command 0x2A -> CASET (param idx 0); 0x2B -> RASET; 0x2C -> RAMWR_HI with x=xs, y=ys; any other command stays in IDLE; data bytes ignored.
  - CASET: collect 4 data bytes (xs_hi, xs_lo, xe_hi, xe_lo); only the low bytes are kept.
    - On the 4th byte: commit if xs_lo<=xe_lo<=XMAX and both high bytes are 0. Otherwise pulse cmd_err and leave the window unchanged.
    - Then IDLE.
  - RASET: same as CASET against YMAX; the low byte is truncated to 7 bits only after validation.
  - RAMWR_HI: data byte -> hold as high byte -> RAMWR_LO.
  - RAMWR_LO: data byte -> pix_rgb={hi,byte}, pix_x=x, pix_y=y, pix_valid pulse in the same cycle pix registers update; then RAMWR_HI.
    - Advance: if x==xe then x=xs and (y==ye ? y=ys with frame_done : y+1); else x+1.
    - Writes continue indefinitely, wrapping the window.
- A command byte in any state aborts the current sequence:
  - partial CASET/RASET params are discarded;
  - a pending high pixel byte is discarded;
  - the command is then decoded as in IDLE in the same cycle.
- Pixel latency: pix_valid asserts in the cycle after byte_valid of the low byte (registered).
- Reset asserted mid-byte or mid-frame returns everything to reset values on the next edge. No pulse is emitted that cycle.
- Throughput requirement: scl high and low phases are each >= 3 clk cycles. Faster scl is out of spec; behaviour is undefined.

Test Plan:
- Send byte 0xA5 with rs=1 (scl half-period 4 clk) -> byte_valid once, byte_data=0xA5, byte_rs=1; no pix_valid in IDLE.
- Send 3 bits, raise cs, lower cs, send 0x3C -> exactly one byte_valid, data=0x3C.
- Send CASET 00,10,00,11; RASET 00,20,00,21; RAMWR + 4 pixels F800,07E0,001F,FFFF -> (16,32,F800), (17,32,07E0), (16,33,001F), (17,33,FFFF); frame_done with the 4th pixel only; 5th pixel 1234 -> (16,32).
- CASET 00,50,00,40 (xs>xe) -> cmd_err pulse; a following RAMWR starts at the previous xs and honours the old xe.
- RAMWR, send high byte 0xAB, then command 0x2C, then AB,CD -> single pixel ABCD at (xs,ys); no pixel from the aborted byte.
- After reset, RAMWR + 160*128 pixels -> last pixel at (159,127) with frame_done; the next pixel is at (0,0).
- Assert reset during RASET param 2, then RAMWR + 1 pixel -> pixel at (0,0); window is full screen.
